// File: rtl/fp_issue_if.sv
// Handshake bundle between the FP issue sequencer and its opcode source, memory
// fetch unit, execution unit and writeback port.
interface fp_issue_if;
    logic       op_valid_i;
    logic [7:0] op_i;
    logic       op_ready_o;
    logic       mem_req_o;
    logic       mem_ack_i;
    logic       ex_start_o;
    logic [2:0] ex_kind_o;
    logic       ex_done_i;
    logic       wb_valid_o;
    logic       wb_swap_o;
    logic       wb_ready_i;
    logic       illegal_o;
    logic       timeout_o;

    modport slave (
        input  op_valid_i, op_i, mem_ack_i, ex_done_i, wb_ready_i,
        output op_ready_o, mem_req_o, ex_start_o, ex_kind_o, wb_valid_o, wb_swap_o,
               illegal_o, timeout_o
    );

    modport master (
        output op_valid_i, op_i, mem_ack_i, ex_done_i, wb_ready_i,
        input  op_ready_o, mem_req_o, ex_start_o, ex_kind_o, wb_valid_o, wb_swap_o,
               illegal_o, timeout_o
    );
endinterface

// File: rtl/fp_issue_seq.sv
// FP opcode issue sequencer: decodes an opcode, optionally fetches a memory operand,
// runs the execution unit under a watchdog and requests writeback.
module fp_issue_seq #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic        clk,
    input logic        reset,
    fp_issue_if.slave  bus
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StWb} state_e;

    state_e     state_q, state_d;
    logic [7:0] wdog_q, wdog_d;
    logic [2:0] kind_q, kind_d;
    logic       start_q, start_d;
    logic       swap_q, swap_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       dec_legal, dec_swap, dec_mem;
    logic [2:0] dec_kind;

    always_comb begin
        dec_legal = 1'b1;
        dec_swap  = 1'b0;
        dec_mem   = 1'b0;
        dec_kind  = 3'd0;
        if (bus.op_i >= 8'd120 && bus.op_i <= 8'd123) begin
            dec_swap = 1'b1;
        end else if (bus.op_i >= 8'd124 && bus.op_i <= 8'd139) begin
            dec_kind = 3'd0;
        end else if (bus.op_i >= 8'd140 && bus.op_i <= 8'd144) begin
            dec_kind = 3'd0;
            dec_mem  = 1'b1;
        end else if (bus.op_i >= 8'd145 && bus.op_i <= 8'd160) begin
            dec_kind = 3'd1;
        end else if (bus.op_i >= 8'd161 && bus.op_i <= 8'd165) begin
            dec_kind = 3'd1;
            dec_mem  = 1'b1;
        end else if (bus.op_i >= 8'd166 && bus.op_i <= 8'd171) begin
            dec_kind = 3'd2;
        end else if (bus.op_i >= 8'd172 && bus.op_i <= 8'd203) begin
            dec_kind = 3'd3;
        end else if (bus.op_i >= 8'd204 && bus.op_i <= 8'd207) begin
            dec_kind = 3'd4;
            dec_mem  = 1'b1;
        end else if (bus.op_i >= 8'd208 && bus.op_i <= 8'd213) begin
            dec_kind = 3'd5;
        end else begin
            dec_legal = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        kind_d    = kind_q;
        start_d   = 1'b0;
        swap_d    = swap_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            // op_ready_o is high only here, so op_valid_i alone marks a handshake.
            StIdle: begin
                if (bus.op_valid_i) begin
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                    end else if (dec_swap) begin
                        state_d = StWb;
                        swap_d  = 1'b1;
                    end else begin
                        kind_d = dec_kind;
                        if (dec_mem) begin
                            state_d = StFetch;
                        end else begin
                            state_d = StExec;
                            wdog_d  = 8'd0;
                            start_d = 1'b1;
                        end
                    end
                end
            end
            StFetch: begin
                if (bus.mem_ack_i) begin
                    state_d = StExec;
                    wdog_d  = 8'd0;
                    start_d = 1'b1;
                end
            end
            StExec: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (bus.ex_done_i) begin
                    state_d = StWb;
                    swap_d  = 1'b0;
                end else if (wdog_q == TmoLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            StWb: begin
                if (bus.wb_ready_i) begin
                    state_d = StIdle;
                    swap_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            wdog_q    <= 8'd0;
            kind_q    <= 3'd0;
            start_q   <= 1'b0;
            swap_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            kind_q    <= kind_d;
            start_q   <= start_d;
            swap_q    <= swap_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.op_ready_o = (state_q == StIdle);
    assign bus.mem_req_o  = (state_q == StFetch);
    assign bus.wb_valid_o = (state_q == StWb);
    assign bus.ex_start_o = start_q;
    assign bus.ex_kind_o  = kind_q;
    assign bus.wb_swap_o  = swap_q;
    assign bus.illegal_o  = illegal_q;
    assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_fp_issue_seq.sv
// Directed bench for fp_issue_seq: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_fp_issue_seq;

    localparam int TO = 8;
    localparam int PhIdle = 0, PhFetch = 1, PhExec = 2, PhWb = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fp_issue_if bus ();

    fp_issue_seq #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode class table: 0 illegal, 1 swap, 2 register op, 3 memory op.
    int cls_typ [256];
    int cls_knd [256];
    int lo [9]  = '{120, 124, 140, 145, 161, 166, 172, 204, 208};
    int hi [9]  = '{123, 139, 144, 160, 165, 171, 203, 207, 213};
    int typ [9] = '{1, 2, 3, 2, 3, 2, 2, 3, 2};
    int knd [9] = '{0, 0, 0, 1, 1, 2, 3, 4, 5};

    initial begin
        for (int i = 0; i < 256; i++) begin
            cls_typ[i] = 0;
            cls_knd[i] = 0;
        end
        for (int r = 0; r < 9; r++) begin
            for (int i = lo[r]; i <= hi[r]; i++) begin
                cls_typ[i] = typ[r];
                cls_knd[i] = knd[r];
            end
        end
    end

    // Model: phase plus timestamps; EXEC expires TO cycles after the entry edge.
    int         ph = PhIdle;
    int         cyc = 0;
    int         exec_at = 0;
    int         m_t;
    bit         armed = 0;
    logic       m_start = 0, m_ill = 0, m_tmo = 0, m_swap = 0;
    logic [2:0] m_kind = 0;

    always @(posedge clk) begin
        cyc++;
        m_start = 0;
        m_ill   = 0;
        m_tmo   = 0;
        if (reset) begin
            ph     = PhIdle;
            m_kind = 0;
            m_swap = 0;
            armed  = 1;
        end else begin
            case (ph)
                PhIdle: if (bus.op_valid_i) begin
                    m_t = cls_typ[bus.op_i];
                    if (m_t == 0) m_ill = 1;
                    else if (m_t == 1) begin
                        ph     = PhWb;
                        m_swap = 1;
                    end else begin
                        m_kind = 3'(cls_knd[bus.op_i]);
                        if (m_t == 3) ph = PhFetch;
                        else begin
                            ph      = PhExec;
                            exec_at = cyc;
                            m_start = 1;
                        end
                    end
                end
                PhFetch: if (bus.mem_ack_i) begin
                    ph      = PhExec;
                    exec_at = cyc;
                    m_start = 1;
                end
                PhExec: begin
                    if (bus.ex_done_i) ph = PhWb;
                    else if (cyc - exec_at == TO) begin
                        ph    = PhIdle;
                        m_tmo = 1;
                    end
                end
                default: if (bus.wb_ready_i) begin
                    ph     = PhIdle;
                    m_swap = 0;
                end
            endcase
        end
    end

    int n_start = 0, n_wb = 0, n_mem = 0, n_ill = 0, n_tmo = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("op_ready", 8'(bus.op_ready_o), 8'(ph == PhIdle));
            chk("mem_req", 8'(bus.mem_req_o), 8'(ph == PhFetch));
            chk("ex_start", 8'(bus.ex_start_o), 8'(m_start));
            chk("ex_kind", 8'(bus.ex_kind_o), 8'(m_kind));
            chk("wb_valid", 8'(bus.wb_valid_o), 8'(ph == PhWb));
            chk("wb_swap", 8'(bus.wb_swap_o), 8'(m_swap && ph == PhWb));
            chk("illegal", 8'(bus.illegal_o), 8'(m_ill));
            chk("timeout", 8'(bus.timeout_o), 8'(m_tmo));
            n_start += int'(bus.ex_start_o === 1'b1);
            n_wb    += int'(bus.wb_valid_o === 1'b1);
            n_mem   += int'(bus.mem_req_o === 1'b1);
            n_ill   += int'(bus.illegal_o === 1'b1);
            n_tmo   += int'(bus.timeout_o === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op);
        bus.op_valid_i = 1'b1;
        bus.op_i       = 8'(op);
        tick();
        bus.op_valid_i = 1'b0;
    endtask

    task automatic drain();
        bus.mem_ack_i  = 1'b1;
        bus.ex_done_i  = 1'b1;
        bus.wb_ready_i = 1'b1;
        for (int i = 0; i < 10 && bus.op_ready_o !== 1'b1; i++) tick();
        chk("drain", 8'(bus.op_ready_o), 8'd1);
        bus.mem_ack_i  = 1'b0;
        bus.ex_done_i  = 1'b0;
        bus.wb_ready_i = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".ready"}, 8'(bus.op_ready_o), 8'd1);
        chk({name, ".outs"}, {1'b0, bus.mem_req_o, bus.ex_start_o, bus.wb_valid_o,
            bus.wb_swap_o, bus.illegal_o, bus.timeout_o, 1'b0}, 8'd0);
        chk({name, ".kind"}, 8'(bus.ex_kind_o), 8'd0);
    endtask

    int bop [18]  = '{119, 120, 139, 140, 144, 145, 160, 161, 165,
                      166, 171, 172, 203, 204, 207, 208, 213, 214};
    int btyp [18] = '{0, 1, 2, 3, 3, 2, 2, 3, 3, 2, 2, 2, 2, 3, 3, 2, 2, 0};
    int bknd [18] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};

    initial begin
        int s0, w0, m0, n, kprev;
        bus.op_valid_i = 1'b0;
        bus.op_i       = 8'd0;
        bus.mem_ack_i  = 1'b0;
        bus.ex_done_i  = 1'b0;
        bus.wb_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");

        // Register add, done four cycles after start.
        s0 = n_start; w0 = n_wb;
        issue(130);
        chk("add.start", 8'(bus.ex_start_o), 8'd1);
        chk("add.kind", 8'(bus.ex_kind_o), 8'd0);
        repeat (4) tick();
        bus.ex_done_i  = 1'b1;
        bus.wb_ready_i = 1'b1;
        tick();
        chk("add.wb", 8'(bus.wb_valid_o), 8'd1);
        bus.ex_done_i = 1'b0;
        tick();
        bus.wb_ready_i = 1'b0;
        chk("add.idle", 8'(bus.op_ready_o), 8'd1);
        tick();
        chk("add.nstart", 8'(n_start - s0), 8'd1);
        chk("add.nwb", 8'(n_wb - w0), 8'd1);

        // Memory divide, ack after three request cycles.
        m0 = n_mem;
        issue(205);
        tick();
        tick();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk("div.start", 8'(bus.ex_start_o), 8'd1);
        chk("div.kind", 8'(bus.ex_kind_o), 8'd4);
        chk("div.nmem", 8'(n_mem - m0), 8'd3);
        drain();

        // Swap and illegal opcodes.
        s0 = n_start; m0 = n_mem; n = n_ill;
        issue(121);
        chk("swap.wb", {6'd0, bus.wb_valid_o, bus.wb_swap_o}, 8'd3);
        drain();
        issue(100);
        chk("ill100", 8'(bus.illegal_o), 8'd1);
        tick();
        issue(214);
        chk("ill214", 8'(bus.illegal_o), 8'd1);
        tick();
        chk("swap.nstart", 8'(n_start - s0), 8'd0);
        chk("swap.nmem", 8'(n_mem - m0), 8'd0);
        chk("ill.count", 8'(n_ill - n), 8'd2);

        // Watchdog expiry, then done landing on the expiry cycle.
        w0 = n_wb;
        issue(180);
        n = 0;
        for (int i = 1; i <= TO + 5; i++) begin
            tick();
            if (bus.timeout_o === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("tmo.cycles", 8'(n), 8'(TO));
        chk("tmo.nwb", 8'(n_wb - w0), 8'd0);
        tick();
        issue(180);
        repeat (TO - 1) tick();
        bus.ex_done_i = 1'b1;
        tick();
        bus.ex_done_i = 1'b0;
        chk("tmo.race.wb", 8'(bus.wb_valid_o), 8'd1);
        chk("tmo.race.tmo", 8'(bus.timeout_o), 8'd0);
        drain();

        // Minimum latencies with responders already asserted.
        bus.ex_done_i  = 1'b1;
        bus.wb_ready_i = 1'b1;
        bus.mem_ack_i  = 1'b1;
        issue(150);
        tick();
        chk("lat.reg", 8'(bus.wb_valid_o), 8'd1);
        tick();
        issue(141);
        tick();
        chk("lat.mem1", 8'(bus.wb_valid_o), 8'd0);
        tick();
        chk("lat.mem2", 8'(bus.wb_valid_o), 8'd1);
        drain();

        // Reset mid-transaction.
        issue(140);
        bus.op_valid_i = 1'b1;
        bus.mem_ack_i  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.op_valid_i = 1'b0;
        bus.mem_ack_i  = 1'b0;
        chk_idle("rst.fetch");
        issue(122);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst.wb");
        issue(190);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst.exec");

        // Class boundaries.
        kprev = 0;
        for (int i = 0; i < 18; i++) begin
            issue(bop[i]);
            if (btyp[i] >= 2) kprev = bknd[i];
            chk($sformatf("bnd%0d.ill", bop[i]), 8'(bus.illegal_o), 8'(btyp[i] == 0));
            chk($sformatf("bnd%0d.swap", bop[i]), 8'(bus.wb_swap_o), 8'(btyp[i] == 1));
            chk($sformatf("bnd%0d.mem", bop[i]), 8'(bus.mem_req_o), 8'(btyp[i] == 3));
            chk($sformatf("bnd%0d.start", bop[i]), 8'(bus.ex_start_o), 8'(btyp[i] == 2));
            chk($sformatf("bnd%0d.kind", bop[i]), 8'(bus.ex_kind_o), 8'(kprev));
            drain();
            tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not finish");
    end

endmodule
